apb_port_demux: RTL and testbench
=================================

Name: apb_port_demux

Overview:
- Parametrised APB fan-out bridge: one upstream APB completer port, N_PORTS downstream APB requester ports.
- Selects the target by a sideband port index.
- Replays each transfer as a full two-phase APB transfer on the selected port, waits for that port's PREADY, and returns read data and error upstream.
- Sits between the system APB bus and the peripheral register blocks; successor to the fixed 6-port write-only demux.

Parameters:
- N_PORTS, 6, number of downstream ports (2..16)
- SEL_W, 4, width of port_sel; must satisfy 2**SEL_W >= N_PORTS
- ADDR_W, 12, address width
- DATA_W, 32, data width (multiple of 8)
- TIMEOUT, 255, access-phase wait limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- psel  in  1  upstream select
- penable  in  1  upstream enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- port_sel  in  SEL_W  target port index, 0-based
- paddr  in  ADDR_W  address
- pwdata  in  DATA_W  write data
- pready  out  1  upstream ready
- prdata  out  DATA_W  upstream read data
- pslverr  out  1  upstream error
- m_psel  out  N_PORTS  per-port select, one-hot or zero
- m_penable  out  1  shared enable
- m_pwrite  out  N_PORTS  per-port write strobe
- m_paddr  out  N_PORTS*ADDR_W  per-port address, slice k = port k
- m_pwdata  out  N_PORTS*DATA_W  per-port write data
- m_pready  in  N_PORTS  per-port ready
- m_prdata  in  N_PORTS*DATA_W  per-port read data
- m_pslverr  in  N_PORTS  per-port error

Behaviour:
- Clocking and reset: clk; reset rst, synchronous, active-low. All outputs are registered.
- Reset values: all outputs 0, state IDLE. Reset mid-transfer aborts immediately; no response is issued.
- State IDLE:
  - On psel=1 && penable=0: latch port_sel, paddr, pwdata, pwrite.
  - If port_sel < N_PORTS, go to FWD_SETUP; otherwise go to ERR.
- State FWD_SETUP (1 cycle):
  - m_psel[k]=1, m_penable=0.
  - m_paddr/m_pwdata/m_pwrite slice k carry the latched values.
  - All other slices and bits are 0.
  - Go to FWD_ACCESS.
- State FWD_ACCESS:
  - m_penable=1; slice k held stable.
  - Samples m_pready[k] each cycle. When it is 1:
    - capture m_prdata slice k (reads only; writes return prdata=0) and m_pslverr[k];
    - drop m_psel and m_penable to 0 and zero all slices;
    - go to RESP.
  - Ready, data and error from non-selected ports are ignored.
- State ERR (1 cycle): no downstream activity; prdata=0, pslverr=1 prepared; go to RESP.
- State RESP:
  - pready=1 for exactly one cycle with the captured prdata and pslverr.
  - Next cycle pready, pslverr and prdata return to 0; state returns to IDLE.
- Latency: minimum 4 cycles from the setup-phase cycle to the pready cycle (IDLE, FWD_SETUP, FWD_ACCESS with m_pready=1, RESP), plus one cycle per downstream wait state. Invalid port: 3 cycles.
- Upstream holds psel/penable/controls until pready. Upstream changes while busy are ignored; the latched values are used.
- Back-to-back: a new setup phase is accepted in the IDLE cycle after RESP.
- psel=1 && penable=1 seen in IDLE (protocol violation): ignored, stays in IDLE.

Optional Feature:
- Macro: APB_DEMUX_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to FWD_ACCESS and increments each cycle that m_pready[k]=0.
  - When the count reaches TIMEOUT, abort: m_psel and m_penable go to 0, then RESP with pslverr=1 and prdata=0.
  - A late m_pready from the aborted port is ignored.
- Not defined: no counter; FWD_ACCESS waits indefinitely.

Test Plan:
1. Write to port 2: paddr=0x0A4, pwdata=0xDEADBEEF, m_pready[2] tied 1 -> m_psel=0b000100 for 2 cycles, m_penable=1 in the 2nd, m_paddr slice2=0x0A4, m_pwdata slice2=0xDEADBEEF, all other slices 0, pready=1 and pslverr=0 four cycles after setup.
2. Read from port 5, m_prdata slice5=0x12345678, m_pready[5] low for 3 cycles -> pready at cycle 7, prdata=0x12345678, then prdata=0.
3. port_sel=7 with N_PORTS=6 -> m_psel stays 0, pready=1 with pslverr=1 and prdata=0 at cycle 3.
4. Port 0 access with m_pslverr[0]=1 and m_pready[1]=1 asserted early on a non-selected port -> unaffected by port 1; pslverr=1 with pready when m_pready[0] rises.
5. rst=0 during FWD_ACCESS -> next cycle all outputs 0, no pready; a fresh write afterwards completes normally.
6. APB_DEMUX_TIMEOUT_EN with TIMEOUT=16, m_pready held 0 -> m_psel drops after 16 access cycles, then pready=1 with pslverr=1.

Source files
------------

// File: rtl/apb_port_demux.sv
// apb_port_demux: APB fan-out bridge. One upstream completer port is replayed
// as a full setup/access transfer on one of N_PORTS downstream requester
// ports, chosen by the sideband port_sel index. Read data and error from the
// selected port are returned upstream with a one-cycle pready pulse.
// Optional feature macro: APB_DEMUX_TIMEOUT_EN (access-phase wait limit).
module apb_port_demux #(
  parameter int N_PORTS = 6,
  parameter int SEL_W   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [SEL_W-1:0]          port_sel,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  output logic                      pready,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pslverr,
  output logic [N_PORTS-1:0]        m_psel,
  output logic                      m_penable,
  output logic [N_PORTS-1:0]        m_pwrite,
  output logic [N_PORTS*ADDR_W-1:0] m_paddr,
  output logic [N_PORTS*DATA_W-1:0] m_pwdata,
  input  logic [N_PORTS-1:0]        m_pready,
  input  logic [N_PORTS*DATA_W-1:0] m_prdata,
  input  logic [N_PORTS-1:0]        m_pslverr
);

  // Elaboration-time guard on the parameter set.
  if (N_PORTS < 2 || N_PORTS > 16 || (2 ** SEL_W) < N_PORTS || TIMEOUT < 1)
  begin : g_param_check
    $error("apb_port_demux: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    FWD_SETUP,
    FWD_ACCESS,
    ERR,
    RESP
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    sel_q;
  logic                write_q;

  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 256) ? 8 : 16;
  logic [CNT_W-1:0]    wait_cnt;
`endif

  // Route ready/data/error of the latched port only; other ports are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ready = m_pready[k];
        sel_err   = m_pslverr[k];
        sel_rdata = m_prdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer sequencer with registered upstream and downstream outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      write_q   <= 1'b0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      m_psel    <= '0;
      m_penable <= 1'b0;
      m_pwrite  <= '0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
`ifdef APB_DEMUX_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
          if (psel && !penable) begin
            sel_q   <= port_sel;
            write_q <= pwrite;
            if (int'(port_sel) < N_PORTS) begin
              // The setup-phase slice is loaded straight from the upstream
              // bus so that FWD_SETUP already presents it registered.
              for (int unsigned k = 0; k < N_PORTS; k++) begin
                if (port_sel == SEL_W'(k)) begin
                  m_psel[k]                    <= 1'b1;
                  m_pwrite[k]                  <= pwrite;
                  m_paddr[k*ADDR_W +: ADDR_W]  <= paddr;
                  m_pwdata[k*DATA_W +: DATA_W] <= pwdata;
                end else begin
                  m_psel[k]                    <= 1'b0;
                  m_pwrite[k]                  <= 1'b0;
                  m_paddr[k*ADDR_W +: ADDR_W]  <= '0;
                  m_pwdata[k*DATA_W +: DATA_W] <= '0;
                end
              end
              state <= FWD_SETUP;
            end else begin
              state <= ERR;
            end
          end
        end

        FWD_SETUP: begin
          m_penable <= 1'b1;
`ifdef APB_DEMUX_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= FWD_ACCESS;
        end

        FWD_ACCESS: begin
          if (sel_ready) begin
            prdata    <= write_q ? '0 : sel_rdata;
            pslverr   <= sel_err;
            pready    <= 1'b1;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= '0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            state     <= RESP;
          end
`ifdef APB_DEMUX_TIMEOUT_EN
          // Abort on the wait cycle that brings the count to TIMEOUT.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            prdata    <= '0;
            pslverr   <= 1'b1;
            pready    <= 1'b1;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= '0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            state     <= RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
`endif
        end

        ERR: begin
          prdata  <= '0;
          pslverr <= 1'b1;
          pready  <= 1'b1;
          state   <= RESP;
        end

        RESP: begin
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_port_demux.sv
// tb_apb_port_demux: table-driven bench for apb_port_demux. Each vector is a
// full upstream transfer; the expected response is queued when the setup
// phase is driven and compared when pready appears. Hand-written sequences
// cover reset state, protocol violation, mid-transfer reset and timeout.
module tb_apb_port_demux;

  localparam int N  = 6;
  localparam int SW = 4;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic            clk;
  logic            rst;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [SW-1:0]   port_sel;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;
  logic [N-1:0]    m_psel;
  logic            m_penable;
  logic [N-1:0]    m_pwrite;
  logic [N*AW-1:0] m_paddr;
  logic [N*DW-1:0] m_pwdata;
  logic [N-1:0]    m_pready;
  logic [N*DW-1:0] m_prdata;
  logic [N-1:0]    m_pslverr;

  apb_port_demux #(
    .N_PORTS(N),
    .SEL_W  (SW),
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .port_sel (port_sel),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_pready (m_pready),
    .m_prdata (m_prdata),
    .m_pslverr(m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
    logic        others_ready;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] exp_addr(input int k, input logic [AW-1:0] a);
    logic [N*AW-1:0] r;
    r = '0;
    for (int p = 0; p < N; p++) if (p == k) r[p*AW +: AW] = a;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_data(input int k, input logic [DW-1:0] d);
    logic [N*DW-1:0] r;
    r = '0;
    for (int p = 0; p < N; p++) if (p == k) r[p*DW +: DW] = d;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_bits(input int k, input logic b);
    logic [N-1:0] r;
    r = '0;
    for (int p = 0; p < N; p++) if (p == k) r[p] = b;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pready"},    256'(pready),    256'(0));
    check({tag, "_prdata"},    256'(prdata),    256'(0));
    check({tag, "_pslverr"},   256'(pslverr),   256'(0));
    check({tag, "_m_psel"},    256'(m_psel),    256'(0));
    check({tag, "_m_penable"}, 256'(m_penable), 256'(0));
    check({tag, "_m_pwrite"},  256'(m_pwrite),  256'(0));
    check({tag, "_m_paddr"},   256'(m_paddr),   256'(0));
    check({tag, "_m_pwdata"},  256'(m_pwdata),  256'(0));
  endtask

  // Drives one upstream transfer starting in the next IDLE cycle and models
  // the selected downstream completer with v.wait_n wait states.
  task automatic run_vec(input vec_t v);
    int    k;
    int    lat;
    bit    valid;
    bit    got;
    resp_t e;
    k     = int'(v.sel);
    valid = (k < N);
    @(negedge clk);
    check("idle_pready", 256'(pready), 256'(0));
    check("idle_prdata", 256'(prdata), 256'(0));
    check("idle_m_psel", 256'(m_psel), 256'(0));
    psel     = 1'b1;
    penable  = 1'b0;
    pwrite   = v.wr;
    port_sel = v.sel;
    paddr    = v.addr;
    pwdata   = v.wdata;
    for (int p = 0; p < N; p++) begin
      m_prdata[p*DW +: DW] = (p == k) ? v.rdata : ~v.rdata;
      m_pslverr[p]         = (p == k) ? v.err : ~v.err;
      m_pready[p]          = (p != k) && v.others_ready;
    end
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    lat = 1;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (pready) begin
        got = 1'b1;
        e   = sb.pop_front();
        check("resp_prdata",  256'(prdata),    256'(e.rdata));
        check("resp_pslverr", 256'(pslverr),   256'(e.err));
        check("resp_latency", 256'(lat),       256'(e.lat));
        check("resp_m_psel",  256'(m_psel),    256'(0));
        check("resp_m_pen",   256'(m_penable), 256'(0));
      end else begin
        if (lat == 2) begin
          penable  = 1'b1;
          // Upstream changes while busy must not reach the downstream port.
          port_sel = v.sel ^ 4'h1;
          paddr    = ~v.addr;
          pwdata   = ~v.wdata;
          pwrite   = ~v.wr;
        end
        if (valid) begin
          check("fwd_m_psel",   256'(m_psel),    256'(exp_bits(k, 1'b1)));
          check("fwd_m_pen",    256'(m_penable), 256'(lat >= 3));
          check("fwd_m_paddr",  256'(m_paddr),   256'(exp_addr(k, v.addr)));
          check("fwd_m_pwdata", 256'(m_pwdata),  256'(exp_data(k, v.wdata)));
          check("fwd_m_pwrite", 256'(m_pwrite),  256'(exp_bits(k, v.wr)));
          m_pready[k] = (lat - 3 >= v.wait_n);
        end else begin
          check("err_m_psel", 256'(m_psel), 256'(0));
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL no_response: got none within %0d cycles want pready at cycle %0d", lat, v.exp_lat);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want $finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    port_sel  = '0;
    paddr     = '0;
    pwdata    = '0;
    m_pready  = '0;
    m_prdata  = '0;
    m_pslverr = '0;

    //            wr    sel   addr     wdata         wait rdata         err   oth   exp_rdata     exp_err lat
    vecs.push_back('{1'b1, 4'd2,  12'h0A4, 32'hDEADBEEF, 0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b0,   4});
    vecs.push_back('{1'b0, 4'd5,  12'h010, 32'h0,        3,  32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0,   7});
    vecs.push_back('{1'b0, 4'd7,  12'h020, 32'h0,        0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1,   3});
    vecs.push_back('{1'b0, 4'd0,  12'h3FC, 32'h0,        2,  32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1,   6});
    vecs.push_back('{1'b1, 4'd1,  12'h555, 32'h01234567, 1,  32'hAAAA5555, 1'b0, 1'b1, 32'h0,        1'b0,   5});
    vecs.push_back('{1'b0, 4'd3,  12'hFFF, 32'hFFFFFFFF, 0,  32'h0F0F0F0F, 1'b0, 1'b0, 32'h0F0F0F0F, 1'b0,   4});
    vecs.push_back('{1'b1, 4'd15, 12'h001, 32'h11111111, 0,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1,   3});
    vecs.push_back('{1'b0, 4'd4,  12'h800, 32'h0,        0,  32'h80000001, 1'b1, 1'b0, 32'h80000001, 1'b1,   4});
`ifdef APB_DEMUX_TIMEOUT_EN
    vecs.push_back('{1'b0, 4'd1,  12'h0C0, 32'h0,        1000, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0,      1'b1,  19});
`else
    vecs.push_back('{1'b0, 4'd1,  12'h0C0, 32'h0,        20, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0,  24});
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // psel with penable in IDLE is a protocol violation and must be ignored.
    @(negedge clk);
    psel     = 1'b1;
    penable  = 1'b1;
    port_sel = 4'd2;
    repeat (3) begin
      @(negedge clk);
      check("viol_m_psel", 256'(m_psel), 256'(0));
      check("viol_pready", 256'(pready), 256'(0));
    end
    psel    = 1'b0;
    penable = 1'b0;

    // Transfers run back-to-back: each starts in the IDLE cycle after RESP.
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

`ifdef APB_DEMUX_TIMEOUT_EN
    // A late ready from the aborted port must not produce a response.
    @(negedge clk);
    psel     = 1'b0;
    penable  = 1'b0;
    m_pready = '1;
    repeat (2) begin
      @(negedge clk);
      check("late_pready", 256'(pready), 256'(0));
      check("late_m_psel", 256'(m_psel), 256'(0));
    end
`endif

    // Reset asserted during the access phase aborts without a response.
    @(negedge clk);
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b0;
    port_sel  = 4'd3;
    paddr     = 12'h155;
    pwdata    = 32'h0;
    m_pready  = '0;
    m_pslverr = '0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("rst_pre_m_pen", 256'(m_penable), 256'(1));
    rst         = 1'b0;
    m_pready[3] = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst     = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_pready", 256'(pready), 256'(0));
      check("midrst_m_psel", 256'(m_psel), 256'(0));
    end
    run_vec('{1'b1, 4'd3, 12'h2A8, 32'hA5A5F00F, 1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5});

    @(negedge clk);
    psel    = 1'b0;
    penable = 1'b0;
    check("final_pready", 256'(pready), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
